// File: rtl/rv32_multicycle_core.sv
// Multi-cycle RV32I/RV32E subset core with a single stallable memory port.
// Flow: FETCH -> DECODE -> EXEC -> [MEM] -> WB, with a terminal HALT on any trap.
module rv32_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      result,
    output logic             wb_valid,
    output logic [CNT_W-1:0] instret,
    output logic             halted,
    output logic [1:0]       trap_cause
);
    localparam int         RW   = $clog2(NUM_REGS);
    localparam logic [5:0] NREG = 6'(NUM_REGS);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    state_t state, state_nx;

    logic [31:0] pc, ir, res_q, npc_q;
    logic [31:0] regs [NUM_REGS];

    logic [6:0] op, f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    assign op  = ir[6:0];
    assign rd  = ir[11:7];
    assign f3  = ir[14:12];
    assign rs1 = ir[19:15];
    assign rs2 = ir[24:20];
    assign f7  = ir[31:25];

    logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_load, is_store, is_opi, is_op, is_ebreak;
    assign is_lui    = (op == 7'h37);
    assign is_auipc  = (op == 7'h17);
    assign is_jal    = (op == 7'h6f);
    assign is_jalr   = (op == 7'h67);
    assign is_br     = (op == 7'h63);
    assign is_load   = (op == 7'h03);
    assign is_store  = (op == 7'h23);
    assign is_opi    = (op == 7'h13);
    assign is_op     = (op == 7'h33);
    assign is_ebreak = (ir == 32'h0010_0073);

    logic uses_rd, uses_rs1, uses_rs2, legal, bad_reg, dec_trap;
    assign uses_rd  = is_lui | is_auipc | is_jal | is_jalr | is_load | is_opi | is_op;
    assign uses_rs1 = is_jalr | is_br | is_load | is_store | is_opi | is_op;
    assign uses_rs2 = is_br | is_store | is_op;
    assign bad_reg  = (uses_rd  && ({1'b0, rd}  >= NREG)) ||
                      (uses_rs1 && ({1'b0, rs1} >= NREG)) ||
                      (uses_rs2 && ({1'b0, rs2} >= NREG));
    assign dec_trap = is_ebreak || !legal || bad_reg;

    always_comb begin
        legal = 1'b0;
        case (op)
            7'h37, 7'h17, 7'h6f: legal = 1'b1;
            7'h67:               legal = (f3 == 3'b000);
            7'h63:               legal = (f3 != 3'b010) && (f3 != 3'b011);
            7'h03, 7'h23:        legal = (f3 == 3'b010);
            7'h13: legal = (f3 == 3'b001) ? (f7 == 7'h00) :
                           (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            7'h33: legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
            default:             legal = 1'b0;
        endcase
    end

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1v, rs2v;
    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u = {ir[31:12], 12'h000};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign rs1v  = regs[rs1[RW-1:0]];
    assign rs2v  = regs[rs2[RW-1:0]];

    // Execute: ALU, branch compare, next PC and the value WB will commit
    // (for loads/stores that value is the effective address).
    logic [31:0] alu_b, alu, ea, pc4, tgt, npc, wbv;
    logic [4:0]  shamt;
    logic        taken, misal;
    always_comb begin
        alu_b = is_op ? rs2v : imm_i;
        shamt = alu_b[4:0];
        case (f3)
            3'b000:  alu = (is_op && f7[5]) ? rs1v - alu_b : rs1v + alu_b;
            3'b001:  alu = rs1v << shamt;
            3'b010:  alu = {31'd0, $signed(rs1v) < $signed(alu_b)};
            3'b011:  alu = {31'd0, rs1v < alu_b};
            3'b100:  alu = rs1v ^ alu_b;
            3'b101:  alu = f7[5] ? 32'($signed(rs1v) >>> shamt) : rs1v >> shamt;
            3'b110:  alu = rs1v | alu_b;
            default: alu = rs1v & alu_b;
        endcase
        case (f3)
            3'b000:  taken = (rs1v == rs2v);
            3'b001:  taken = (rs1v != rs2v);
            3'b100:  taken = ($signed(rs1v) < $signed(rs2v));
            3'b101:  taken = !($signed(rs1v) < $signed(rs2v));
            3'b110:  taken = (rs1v < rs2v);
            3'b111:  taken = !(rs1v < rs2v);
            default: taken = 1'b0;
        endcase
        pc4 = pc + 32'd4;
        ea  = rs1v + (is_store ? imm_s : imm_i);
        tgt = is_jal  ? pc + imm_j :
              is_jalr ? {ea[31:1], 1'b0} : pc + imm_b;
        npc = (is_jal || is_jalr || (is_br && taken)) ? tgt : pc4;
        wbv = is_lui                ? imm_u :
              is_auipc              ? pc + imm_u :
              (is_jal || is_jalr)   ? pc4 :
              (is_load || is_store) ? ea : alu;
        misal = ((is_load || is_store) && ea[1:0] != 2'b00) ||
                ((is_jal || is_jalr || (is_br && taken)) && tgt[1:0] != 2'b00);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:  if (mem_ready) state_nx = S_DECODE;
            S_DECODE: state_nx = dec_trap ? S_HALT : S_EXEC;
            S_EXEC:   state_nx = misal ? S_HALT : (is_load || is_store) ? S_MEM : S_WB;
            S_MEM:    if (mem_ready) state_nx = S_WB;
            S_WB:     state_nx = S_FETCH;
            default:  state_nx = S_HALT;
        endcase
    end

    // Memory handshake: while mem_req is high, mem_addr/mem_we/mem_wdata hold steady;
    // the transfer completes in the cycle mem_ready is also high. mem_ready alone is ignored.
    // Outputs are gated by rst so a reset drops an in-flight request at once.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        halted    = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = pc;
                end
                S_MEM: begin
                    mem_req   = 1'b1;
                    mem_we    = is_store;
                    mem_addr  = res_q;
                    mem_wdata = is_store ? rs2v : 32'd0;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            ir         <= 32'd0;
            res_q      <= 32'd0;
            npc_q      <= 32'd0;
            result     <= 32'd0;
            wb_valid   <= 1'b0;
            instret    <= '0;
            trap_cause <= 2'd0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                S_FETCH:  if (mem_ready) ir <= mem_rdata;
                S_DECODE: begin
                    if (is_ebreak)            trap_cause <= 2'd3;
                    else if (!legal || bad_reg) trap_cause <= 2'd1;
                end
                S_EXEC: begin
                    res_q <= wbv;
                    npc_q <= npc;
                    if (misal) trap_cause <= 2'd2;
                end
                S_MEM:    if (mem_ready && !is_store) res_q <= mem_rdata;
                S_WB: begin
                    pc       <= npc_q;
                    instret  <= instret + CNT_W'(1);
                    wb_valid <= 1'b1;
                    if (uses_rd && rd != 5'd0) result <= res_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'd0;
        end else if (state == S_WB && uses_rd && rd != 5'd0) begin
            regs[rd[RW-1:0]] <= res_q;
        end
    end
endmodule
